// File: rtl/ram_arb_pkg.sv
// Shared defaults and state type for the two-client RAM arbiter.
package ram_arb_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 6;
  localparam int DEF_DEPTH  = 32;

  typedef enum logic {
    IDLE   = 1'b0,
    RD_CAP = 1'b1
  } arb_state_t;

endpackage

// File: rtl/ram_access_arbiter_if.sv
// Client-side bus of the RAM arbiter: two requesters share one set of wires.
interface ram_access_arbiter_if #(
  parameter int DATA_W = ram_arb_pkg::DEF_DATA_W,
  parameter int ADDR_W = ram_arb_pkg::DEF_ADDR_W
);

  logic [1:0]          req;
  logic [1:0]          we;
  logic [2*ADDR_W-1:0] addr;
  logic [2*DATA_W-1:0] wdata;
  logic [1:0]          gnt;
  logic [1:0]          rvalid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          err;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata, err
  );

endinterface

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick; the requester that did not win last time has priority.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant,
  output logic       id
);

  always_comb begin
    id    = 1'b0;
    grant = 2'b00;
    case (req)
      2'b01:   id = 1'b0;
      2'b10:   id = 1'b1;
      2'b11:   id = ~last;
      default: id = 1'b0;
    endcase
    if (|req) begin
      grant = id ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/ram_access_arbiter.sv
// Shares one single-port synchronous RAM between two clients, sequencing the
// two-cycle read and flagging out-of-range addresses.
module ram_access_arbiter
  import ram_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst,
  ram_access_arbiter_if.slave  bus,
  output logic                 ram_en,
  output logic                 ram_we,
  output logic [ADDR_W-1:0]    ram_addr,
  output logic [DATA_W-1:0]    ram_wdata,
  input  logic [DATA_W-1:0]    ram_q
);

  localparam logic [ADDR_W:0] DEPTH_LIM = DEPTH[ADDR_W:0];

  arb_state_t        state_reg, state_next;
  logic              last_reg;
  logic              id_reg;
  logic [ADDR_W-1:0] cap_addr_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic [1:0]        rvalid_reg;
  logic [1:0]        err_reg;

  logic [ADDR_W-1:0] addr_arr  [2];
  logic [DATA_W-1:0] wdata_arr [2];
  logic [1:0]        pick_oh;
  logic              pick_id;
  logic [ADDR_W-1:0] win_addr;
  logic              win_we;
  logic              win_legal;
  logic              grant_en;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_unpack
      assign addr_arr[gi]  = bus.addr[gi*ADDR_W +: ADDR_W];
      assign wdata_arr[gi] = bus.wdata[gi*DATA_W +: DATA_W];
    end
  endgenerate

  rr_arb2 u_rr_arb2 (
    .req   (bus.req),
    .last  (last_reg),
    .grant (pick_oh),
    .id    (pick_id)
  );

  assign win_addr  = addr_arr[pick_id];
  assign win_we    = bus.we[pick_id];
  assign win_legal = ({1'b0, win_addr} < DEPTH_LIM);
  assign grant_en  = (state_reg == IDLE) && (|bus.req);

  // Outputs are forced quiet while reset is held, since gnt/ram_* are combinational.
  always_comb begin
    state_next = state_reg;
    bus.gnt    = 2'b00;
    ram_en     = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = '0;
    ram_wdata  = '0;
    if (!rst) begin
      case (state_reg)
        IDLE: begin
          if (|bus.req) begin
            bus.gnt = pick_oh;
            if (win_legal) begin
              ram_en   = 1'b1;
              ram_we   = win_we;
              ram_addr = win_addr;
              if (win_we) begin
                ram_wdata = wdata_arr[pick_id];
              end else begin
                state_next = RD_CAP;
              end
            end
          end
        end
        RD_CAP: begin
          // Hold en/addr so the RAM keeps q driven while it is captured.
          ram_en     = 1'b1;
          ram_addr   = cap_addr_reg;
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      last_reg     <= 1'b1;
      id_reg       <= 1'b0;
      cap_addr_reg <= '0;
      rdata_reg    <= '0;
      rvalid_reg   <= 2'b00;
      err_reg      <= 2'b00;
    end else begin
      state_reg  <= state_next;
      rvalid_reg <= 2'b00;
      err_reg    <= 2'b00;
      if (state_reg == RD_CAP) begin
        rdata_reg          <= ram_q;
        rvalid_reg[id_reg] <= 1'b1;
      end
      if (grant_en) begin
        last_reg <= pick_id;
        if (!win_legal) begin
          err_reg[pick_id] <= 1'b1;
        end else if (!win_we) begin
          id_reg       <= pick_id;
          cap_addr_reg <= win_addr;
        end
      end
    end
  end

  assign bus.rvalid = rvalid_reg;
  assign bus.rdata  = rdata_reg;
  assign bus.err    = err_reg;

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Directed bench for ram_access_arbiter with a cycle-scheduled reference model and a behavioural RAM.
module tb_ram_access_arbiter;

  localparam int DW    = 8;
  localparam int AW    = 6;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  ram_access_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  wire  [DW-1:0] ram_q;

  ram_access_arbiter #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_q     (ram_q)
  );

  // Requester drive
  logic          t_req   [2];
  logic          t_we    [2];
  logic [AW-1:0] t_addr  [2];
  logic [DW-1:0] t_wdata [2];
  assign bus.req   = {t_req[1], t_req[0]};
  assign bus.we    = {t_we[1], t_we[0]};
  assign bus.addr  = {t_addr[1], t_addr[0]};
  assign bus.wdata = {t_wdata[1], t_wdata[0]};

  // Behavioural RAM: address registered, q driven only while en && !we
  logic [DW-1:0] ram_mem [DEPTH];
  logic [AW-1:0] ram_addr_q;
  bit            ram_init = 1'b0;
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < DEPTH; i++) ram_mem[i] <= DW'(i * 7 + 3);
      ram_init <= 1'b1;
    end else if (ram_en) begin
      if (ram_we) ram_mem[ram_addr[4:0]] <= ram_wdata;
      ram_addr_q <= ram_addr;
    end
  end
  assign ram_q = (ram_en && !ram_we) ? ram_mem[ram_addr_q[4:0]] : {DW{1'bz}};

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: schedules rvalid/err/capture by absolute cycle number
  int            m_last;
  int            m_rdata;
  int            m_pend_rv   [8];
  int            m_pend_data [8];
  int            m_pend_err  [8];
  int            m_cap       [8];
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_init = 1'b0;

  always @(negedge clk) begin
    int            s, w, a;
    logic [1:0]    e_gnt, e_rv, e_err;
    logic          e_en, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    if (!m_init) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = DW'(i * 7 + 3);
      m_init = 1'b1;
    end
    if (rst) begin
      m_last  = 1;
      m_rdata = 0;
      for (int i = 0; i < 8; i++) begin
        m_pend_rv[i] = -1; m_pend_err[i] = -1; m_cap[i] = -1; m_pend_data[i] = 0;
      end
      chk("rst_gnt", 32'(bus.gnt), 0);
      chk("rst_rvalid", 32'(bus.rvalid), 0);
      chk("rst_err", 32'(bus.err), 0);
      chk("rst_ram_en", 32'(ram_en), 0);
      chk("rst_ram_we", 32'(ram_we), 0);
      chk("rst_rdata", 32'(bus.rdata), 0);
    end else begin
      s = cyc % 8;
      e_gnt = 0; e_rv = 0; e_err = 0; e_en = 0; e_we = 0; e_addr = 0; e_wd = 0;
      if (m_pend_rv[s] >= 0) begin
        e_rv[m_pend_rv[s]] = 1'b1;
        m_rdata = m_pend_data[s];
      end
      if (m_pend_err[s] >= 0) e_err[m_pend_err[s]] = 1'b1;
      if (m_cap[s] >= 0) begin
        e_en   = 1'b1;
        e_addr = AW'(m_cap[s]);
      end else if (bus.req != 2'b00) begin
        w = (bus.req == 2'b11) ? 1 - m_last : (bus.req[1] ? 1 : 0);
        e_gnt[w] = 1'b1;
        m_last   = w;
        a = w ? int'(bus.addr[2*AW-1:AW]) : int'(bus.addr[AW-1:0]);
        if (a >= DEPTH) begin
          m_pend_err[(cyc + 1) % 8] = w;
        end else begin
          e_en   = 1'b1;
          e_we   = bus.we[w];
          e_addr = AW'(a);
          if (bus.we[w]) begin
            e_wd     = w ? bus.wdata[2*DW-1:DW] : bus.wdata[DW-1:0];
            m_mem[a] = e_wd;
          end else begin
            m_cap[(cyc + 1) % 8]       = a;
            m_pend_rv[(cyc + 2) % 8]   = w;
            m_pend_data[(cyc + 2) % 8] = int'(m_mem[a]);
          end
        end
      end
      m_pend_rv[s] = -1; m_pend_err[s] = -1; m_cap[s] = -1;
      chk("gnt", 32'(bus.gnt), 32'(e_gnt));
      chk("rvalid", 32'(bus.rvalid), 32'(e_rv));
      chk("err", 32'(bus.err), 32'(e_err));
      chk("rdata", 32'(bus.rdata), 32'(m_rdata));
      chk("ram_en", 32'(ram_en), 32'(e_en));
      chk("ram_we", 32'(ram_we), 32'(e_we));
      chk("ram_addr", 32'(ram_addr), 32'(e_addr));
      chk("ram_wdata", 32'(ram_wdata), 32'(e_wd));
    end
  end

  // Caller is at posedge+1; returns at posedge+1 of the cycle after the grant.
  task automatic do_req(input int id, input bit wr, input int a, input int d, output int gc);
    int n = 0;
    t_req[id] = 1'b1; t_we[id] = wr; t_addr[id] = AW'(a); t_wdata[id] = DW'(d);
    @(negedge clk);
    while (!bus.gnt[id] && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("gnt_seen_r%0d", id), 32'(bus.gnt[id]), 1);
    gc = cyc;
    $display("req%0d %s addr=%0d data=0x%0h granted at cycle %0d", id, wr ? "WR" : "RD", a, d, gc);
    @(posedge clk); #1;
    t_req[id] = 1'b0;
  endtask

  task automatic do_read(input int id, input int a, input int exp, output int gc);
    do_req(id, 1'b0, a, 0, gc);
    @(negedge clk);
    chk("rd_hold_en", 32'(ram_en), 1);
    chk("rd_hold_we", 32'(ram_we), 0);
    @(negedge clk);
    chk($sformatf("rd_rvalid_r%0d", id), 32'(bus.rvalid[id]), 1);
    chk($sformatf("rd_data_a%0d", a), 32'(bus.rdata), 32'(exp));
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int ga, gb, g0a, g0b, g1a, g1b, g;
    for (int i = 0; i < 2; i++) begin
      t_req[i] = 1'b0; t_we[i] = 1'b0; t_addr[i] = '0; t_wdata[i] = '0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Contention straight out of reset: requester 0 first, requester 1 two cycles later
    fork
      do_read(0, 5, 8'h26, ga);
      do_read(1, 10, 8'h49, gb);
    join
    chk("t2_spacing", 32'(gb - ga), 2);

    // Write then read back
    do_req(0, 1'b1, 3, 8'hA5, g);
    do_read(0, 3, 8'hA5, g);

    // Continuous writes from both: alternating grants, no gaps
    fork
      begin do_req(0, 1'b1, 16, 8'h11, g0a); do_req(0, 1'b1, 17, 8'h12, g0b); end
      begin do_req(1, 1'b1, 20, 8'h21, g1a); do_req(1, 1'b1, 21, 8'h22, g1b); end
    join
    chk("t3_r0_period", 32'(g0b - g0a), 2);
    chk("t3_r1_period", 32'(g1b - g1a), 2);
    chk("t3_adjacent", 32'((g1a > g0a) ? g1a - g0a : g0a - g1a), 1);
    do_read(0, 16, 8'h11, g);
    do_read(1, 17, 8'h12, g);
    do_read(0, 20, 8'h21, g);
    do_read(1, 21, 8'h22, g);

    // Out-of-range read, followed immediately by a legal write
    do_req(1, 1'b0, 40, 0, ga);
    fork
      begin
        @(negedge clk);
        chk("t4_err", 32'(bus.err), 32'h2);
        chk("t4_no_rvalid", 32'(bus.rvalid), 0);
      end
      do_req(1, 1'b1, 2, 8'h5C, gb);
    join
    chk("t4_next_grant", 32'(gb - ga), 1);
    do_read(0, 2, 8'h5C, g);

    // rvalid for a read coincides with grant of another client's write
    do_req(0, 1'b0, 17, 0, ga);
    t_req[1] = 1'b1; t_we[1] = 1'b1; t_addr[1] = 6'd7; t_wdata[1] = 8'h3C;
    @(negedge clk);
    chk("t6_no_grant_in_cap", 32'(bus.gnt), 0);
    @(negedge clk);
    chk("t6_gnt", 32'(bus.gnt), 32'h2);
    chk("t6_rvalid", 32'(bus.rvalid), 32'h1);
    chk("t6_rdata", 32'(bus.rdata), 32'h12);
    @(posedge clk); #1;
    t_req[1] = 1'b0;
    do_read(1, 7, 8'h3C, g);

    // Reset during the capture cycle drops the read and restores the pointer
    do_req(0, 1'b0, 3, 0, ga);
    rst = 1'b1;
    #1;
    chk("t5_rst_ram_en", 32'(ram_en), 0);
    chk("t5_rst_rvalid", 32'(bus.rvalid), 0);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t5_no_rvalid", 32'(bus.rvalid), 0);
    chk("t5_rdata_cleared", 32'(bus.rdata), 0);
    @(posedge clk); #1;
    fork
      do_read(0, 3, 8'hA5, ga);
      do_read(1, 4, 8'h1F, gb);
    join
    chk("t5_r0_first", 32'(gb - ga), 2);

    @(posedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
